fifo_wr_ctrl: RTL
=================

FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: RAM address width; DEPTH = 2**ADDR_WIDTH; pointer width PW = ADDR_WIDTH+1.
REQ-002 SHALL have parameter AFULL_MARGIN, default 2: afull asserts when free entries <= AFULL_MARGIN; legal range 1..DEPTH-1.
REQ-003 SHALL run on one clock and use an asynchronous, active-low reset.
REQ-004 clk  input  1  write-domain clock; all state on rising edge.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 wr_en  input  1  write request from producer.
REQ-007 rgray_async  input  PW  read-side gray pointer, asynchronous to clk.
REQ-008 clr_ovf  input  1  clears sticky overflow.
REQ-009 wr_fire  output  1  RAM write enable; combinational.
REQ-010 waddr  output  ADDR_WIDTH  RAM write address; registered.
REQ-011 wgray  output  PW  registered gray write pointer, for the read domain.
REQ-012 full  output  1  registered full flag.
REQ-013 afull  output  1  registered almost-full flag.
REQ-014 wcount  output  PW  registered occupancy estimate, 0..DEPTH.
REQ-015 overflow  output  1  sticky flag: write attempted while full.

Function
REQ-016 SHALL set wr_fire = wr_en & ~full; a write while full is dropped and the pointer does not move.
REQ-017 SHALL synchronise rgray_async through two flops (sync1 -> rgray_s); no other logic uses rgray_async.
REQ-018 SHALL hold binary write pointer wbin (PW bits): wbin_next = wbin + wr_fire, wrapping mod 2**PW.
REQ-019 SHALL compute gnext = wbin_next ^ (wbin_next >> 1) and register it as wgray; wgray changes by at most one bit per cycle.
REQ-020 SHALL drive waddr = wbin[ADDR_WIDTH-1:0], i.e. the slot for the current write; wr_fire and waddr are valid in the same cycle.
REQ-021 SHALL register full <= (gnext == {~rgray_s[PW-1:PW-2], rgray_s[PW-3:0]}); for ADDR_WIDTH=1 only the MSB pair rule applies, so both bits invert.
REQ-022 SHALL register wcount <= (wbin_next - gray2bin(rgray_s)) mod 2**PW.
REQ-023 SHALL register afull <= (DEPTH - wcount_next) <= AFULL_MARGIN.
REQ-024 Full SHALL assert on the same edge that commits the write filling the last entry; no cycle may exist where full=0 and the FIFO holds DEPTH entries.
REQ-025 Full SHALL deassert no earlier than the 3rd rising edge after an rgray_async change; early deassertion is forbidden, late deassertion is allowed.
REQ-026 SHALL set overflow on any cycle with wr_en & full; it holds until clr_ovf. If clr_ovf and a new overflow occur in the same cycle, set wins.
REQ-027 Pointer wrap (wbin 2**PW-1 -> 0) SHALL be seamless; full and wcount stay correct across the wrap.

Reset
REQ-028 On rstn low, SHALL immediately clear wbin, wgray, waddr, sync1, rgray_s, full, afull, wcount and overflow to 0; wr_fire is then 0 only if wr_en=0.
REQ-029 Reset asserted mid-operation SHALL discard all state; the block must not write on the first edge after release unless wr_en=1.
REQ-030 SHALL assume the read domain resets together with it; after reset both pointers are 0 and the FIFO is empty.

Structure
REQ-031 Package fifo_pkg SHALL hold the gray2bin function and the PW/DEPTH derivation helper; the read-side controller shares it.
REQ-032 SHALL instantiate one grayctr (WIDTH=PW, inc = wr_fire zero-extended) for wbin/gnext/wgray; the synchroniser, flag logic and overflow logic stay inline.

Verification (ADDR_WIDTH=2, DEPTH=4, AFULL_MARGIN=1)
REQ-033 Reset, rgray_async=0, wr_en=1 for 4 cycles -> waddr 0,1,2,3; wgray 1,3,2,6; full=1 after the 4th edge; afull=1 after the 3rd; wcount=4.
REQ-034 While full, wr_en=1 for 2 cycles -> wr_fire=0, pointer frozen, overflow=1 and held; clr_ovf pulse -> overflow=0 next edge.
REQ-035 While full, rgray_async 0->1 -> full stays 1 for 2 edges and clears on the 3rd; wcount=3.
REQ-036 Stream 20 writes with rgray_async tracking 2 cycles behind -> wgray wraps 4 (gray) -> 0 cleanly; no false full; each wgray step flips exactly one bit.
REQ-037 rstn pulsed low mid-burst at wcount=3 -> all outputs 0 asynchronously; the next write after release goes to waddr=0.
REQ-038 wr_en=1 with clr_ovf=1 while full -> overflow remains 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO write and read controllers.
// Latency: none, functions and constants only.
// Backpressure: not applicable.
package fifo_pkg;

  // Widest pointer the helper functions handle. Callers zero-extend into it.
  localparam int MAXW = 32;

  // Pointer width: one extra bit to tell a full FIFO from an empty one.
  function automatic int calc_pw(input int aw);
    return aw + 1;
  endfunction

  // Number of RAM entries addressed by aw address bits.
  function automatic int calc_depth(input int aw);
    return 1 << aw;
  endfunction

  // Gray to binary. Each binary bit is the XOR of all gray bits at or above it.
  // Zero bits above the real pointer width leave the result unchanged.
  function automatic logic [MAXW-1:0] gray2bin(input logic [MAXW-1:0] g);
    logic [MAXW-1:0] b;
    b[MAXW-1] = g[MAXW-1];
    for (int i = MAXW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // XOR mask for the full test: invert the top two bits of a pw-wide gray
  // pointer. When pw is 2 this covers both bits.
  function automatic logic [MAXW-1:0] full_mask(input int pw);
    logic [MAXW-1:0] m;
    m = {{(MAXW-2){1'b0}}, 2'b11};
    return m << (pw - 2);
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bundle between producer/read domain and the write controller.
// Latency: none, wires only.
// Backpressure: producer must treat wr_fire as the accept strobe.
interface fifo_wr_ctrl_if #(
  parameter int ADDR_WIDTH = 4
);
  localparam int PW = fifo_pkg::calc_pw(ADDR_WIDTH);

  logic                  wr_en;
  logic [PW-1:0]         rgray_async;
  logic                  clr_ovf;
  logic                  wr_fire;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [PW-1:0]         wgray;
  logic                  full;
  logic                  afull;
  logic [PW-1:0]         wcount;
  logic                  overflow;

  // Producer / environment side.
  modport master (
    output wr_en, rgray_async, clr_ovf,
    input  wr_fire, waddr, wgray, full, afull, wcount, overflow
  );

  // Controller side.
  modport slave (
    input  wr_en, rgray_async, clr_ovf,
    output wr_fire, waddr, wgray, full, afull, wcount, overflow
  );

endinterface

// File: rtl/grayctr.sv
// Binary counter with a registered gray-coded copy of its value.
// Latency: next values combinational, bin_q/gray_q one cycle.
// Backpressure: none, advances by inc every cycle.
module grayctr #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] inc,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] bin_d,
  output logic [WIDTH-1:0] gray_d,
  output logic [WIDTH-1:0] gray_q
);

  // Next binary value wraps naturally. Its gray image changes one bit per step.
  always_comb begin
    bin_d  = bin_q + inc;
    gray_d = bin_d ^ (bin_d >> 1);
  end

  // Hold both encodings so the gray output is glitch-free for the other domain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
    end
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-side controller: pointer, gray export, full/afull/occupancy, overflow.
// Latency: wr_fire combinational; flags and pointers registered, read pointer seen after 2 syncs.
// Backpressure: writes while full are dropped and flagged in sticky overflow.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic         clk,
  input  logic         rstn,
  fifo_wr_ctrl_if.slave bus
);

  localparam int PW    = calc_pw(ADDR_WIDTH);
  localparam int DEPTH = calc_depth(ADDR_WIDTH);

  // One extra bit so DEPTH itself and the free-entry difference fit.
  localparam logic [PW:0]   DEPTH_X   = (PW+1)'(DEPTH);
  localparam logic [PW:0]   MARGIN_X  = (PW+1)'(AFULL_MARGIN);
  localparam logic [PW-1:0] FULL_MASK = PW'(full_mask(PW));

  logic          wr_fire;
  logic [PW-1:0] wbin_q;
  logic [PW-1:0] wbin_d;
  logic [PW-1:0] gnext;
  logic [PW-1:0] wgray_q;

  logic [PW-1:0] sync1_q,    sync1_d;
  logic [PW-1:0] rgray_s_q,  rgray_s_d;
  logic          full_q,     full_d;
  logic          afull_q,    afull_d;
  logic [PW-1:0] wcount_q,   wcount_d;
  logic          overflow_q, overflow_d;
  logic [PW-1:0] rbin;
  logic [PW:0]   free_d;

  // A write is accepted only while the registered full flag is low.
  assign wr_fire = bus.wr_en & ~full_q;

  grayctr #(
    .WIDTH (PW)
  ) u_wptr (
    .clk    (clk),
    .rstn   (rstn),
    .inc    ({{(PW-1){1'b0}}, wr_fire}),
    .bin_q  (wbin_q),
    .bin_d  (wbin_d),
    .gray_d (gnext),
    .gray_q (wgray_q)
  );

  // Two-stage synchroniser; only this path touches the asynchronous pointer.
  always_comb begin
    sync1_d   = bus.rgray_async;
    rgray_s_d = sync1_q;
  end

  // Flags are computed from the post-write pointer so full rises on the filling edge.
  // The synchronised read pointer lags, so full can only clear late, never early.
  always_comb begin
    rbin       = PW'(gray2bin(MAXW'(rgray_s_q)));
    full_d     = (gnext == (rgray_s_q ^ FULL_MASK));
    wcount_d   = wbin_d - rbin;
    free_d     = DEPTH_X - {1'b0, wcount_d};
    afull_d    = (free_d <= MARGIN_X);
    overflow_d = (bus.wr_en & full_q) | (overflow_q & ~bus.clr_ovf);
  end

  // Synchroniser and flag registers; reset clears everything to the empty state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q    <= '0;
      rgray_s_q  <= '0;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      wcount_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      rgray_s_q  <= rgray_s_d;
      full_q     <= full_d;
      afull_q    <= afull_d;
      wcount_q   <= wcount_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.wr_fire  = wr_fire;
  assign bus.waddr    = wbin_q[ADDR_WIDTH-1:0];
  assign bus.wgray    = wgray_q;
  assign bus.full     = full_q;
  assign bus.afull    = afull_q;
  assign bus.wcount   = wcount_q;
  assign bus.overflow = overflow_q;

endmodule
